cory_arb4_pkt: RTL and testbench
================================

# cory_arb4_pkt

Four-requester packet arbiter with a registered output stage. It shares one downstream valid/ready channel between four valid/ready sources and uses round-robin or fixed priority. A grant is held for a whole packet, delimited by a last flag, so packets from different ports never interleave. The output carries a 2-bit source tag so downstream demux/return logic can route responses.

## Interface
- N, 8, data bits per beat
- ROUND, 1, 1: round-robin rotation after each packet; 0: fixed priority 0>1>2>3
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_aK_v  in  1  port K valid (K = 0..3)
- i_aK_d  in  N  port K data
- i_aK_l  in  1  port K last beat of packet
- o_aK_r  out  1  port K ready
- o_z_v  out  1  output valid
- o_z_d  out  N  output data
- o_z_l  out  1  output last
- o_z_s  out  2  output source port index
- i_z_r  in  1  output ready
- o_busy  out  1  arbiter locked mid-packet

## Operation
- Transfer on any port happens when valid & ready are both high at a clock edge.
- Load enable: ld = !o_z_v | i_z_r. The output register accepts a beat when ld is high.
- State IDLE: the candidate is the first valid port scanning ptr, ptr+1, ... modulo 4.
- In IDLE, o_aK_r = ld & (K == candidate). All other readies are 0.
- State LOCK: owner g is fixed. o_ag_r = ld, and every other port's ready is 0, whatever their valids are.
- Accepting a beat with l=0 in IDLE: go to LOCK, owner = that port, o_busy = 1.
- Accepting a beat with l=1 in LOCK: go to IDLE, o_busy = 0.
- Accepting a beat with l=1 in IDLE: stay in IDLE (single-beat packet).
- Pointer update on each accepted l=1 beat from port g:
  - ROUND=1: ptr <= (g+1) mod 4, with 2-bit wrap (3 -> 0).
  - ROUND=0: ptr stays 0.
- Owner drops valid mid-packet: the arbiter stays in LOCK and waits. No timeout.
- Output register on an accept: o_z_d/o_z_l/o_z_s <= beat/last/port, and o_z_v <= 1.
- Output register with no accept while i_z_r=1: o_z_v <= 0.
- o_z_v holds with stable data while i_z_r=0.
- Ready may depend combinationally on i_aK_v and i_z_r. Valid never depends on ready.

## Timing
- Reset values: o_z_v=0, o_z_d=0, o_z_l=0, o_z_s=0, o_busy=0, state IDLE, ptr=0.
- Reset is asynchronous, so assertion mid-packet drops the partial packet and the register contents immediately.
- Latency is 1 cycle from input accept to o_z_v.
- Throughput is 1 beat/cycle while i_z_r=1, including back-to-back packets from different ports. There is no idle cycle at arbitration.
- Grant decision for the next packet uses the ptr value updated at the edge that accepted the previous last beat.
- Output stall (i_z_r=0, o_z_v=1): all o_aK_r=0 on the same cycle.

## Configuration
- CORY_ARB4_PKT_PKT_EN defined: packet locking as described.
- Macro undefined:
  - i_aK_l is ignored and treated as 1, so every beat is its own packet.
  - The LOCK state is never entered and o_busy is tied to 0.
  - o_z_l is always 1 when o_z_v is high.
  - Rotation happens per beat.

## Structure
- Shared package cory_pkg:
  - State encoding constants ST_IDLE=0, ST_LOCK=1.
  - Port-index width constant AW=2.
- Sub-module cory_rr_pick4: combinational 4-way first-valid-from-pointer picker. Inputs are the valid vector and ptr; outputs are found and index[1:0]. It is reusable by other arbiters.
- The output register stays in this block.

## Test plan
- Single beats, all four ports valid continuously, i_z_r=1, ROUND=1 -> o_z_s sequence 0,1,2,3,0 on consecutive cycles, o_z_v=1 every cycle after the first.
- Port 2 sends a 3-beat packet (l=0,0,1) while ports 0 and 1 stay valid -> o_z_s=2 for three beats. o_a0_r=o_a1_r=0 throughout, o_busy=1 after beat 1, and port 3 is considered next.
- Port 1 drops valid after beat 1 of 4 for 5 cycles, others valid -> no output beats in the gap, o_busy stays 1, and port 1 resumes with o_z_s=1.
- i_z_r=0 for 4 cycles with o_z_v=1, d=0xA5 -> o_z_d holds 0xA5 and all o_aK_r=0. Transfer resumes on the cycle i_z_r returns to 1.
- ROUND=0, ports 0 and 3 both valid with single beats -> port 0 always wins and port 3 starves while port 0 is valid.
- reset_n pulsed low in LOCK mid-packet -> o_z_v=0, o_busy=0, ptr=0 immediately. The first grant after release goes to the lowest valid port from 0.

Source files
------------

// File: rtl/cory_arb4_pkt_pkg.sv
// Shared constants for the cory_arb4_pkt arbiter and its round-robin picker.
// Package is named cory_pkg so other cory arbiters can reuse it.
package cory_pkg;

  localparam int unsigned AW = 2;
  localparam int unsigned NP = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Next round-robin start position; 2-bit wrap takes 3 back to 0.
  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

endpackage

// File: rtl/cory_arb4_pkt_if.sv
// Four-source valid/ready bundle plus the shared output channel of cory_arb4_pkt.
// Signal prefixes are from the arbiter's point of view (i_ into it, o_ out of it).
interface cory_arb4_pkt_if #(
  parameter int unsigned N = 8
);

  logic [3:0]        i_a_v;
  logic [3:0][N-1:0] i_a_d;
  logic [3:0]        i_a_l;
  logic [3:0]        o_a_r;

  logic                     o_z_v;
  logic [N-1:0]             o_z_d;
  logic                     o_z_l;
  logic [cory_pkg::AW-1:0]  o_z_s;
  logic                     i_z_r;
  logic                     o_busy;

  modport slave (
    input  i_a_v, i_a_d, i_a_l, i_z_r,
    output o_a_r, o_z_v, o_z_d, o_z_l, o_z_s, o_busy
  );

  modport master (
    output i_a_v, i_a_d, i_a_l, i_z_r,
    input  o_a_r, o_z_v, o_z_d, o_z_l, o_z_s, o_busy
  );

endinterface

// File: rtl/cory_rr_pick4.sv
// Combinational 4-way picker: first set bit of i_v scanning from i_ptr upward, mod 4.
module cory_rr_pick4
  import cory_pkg::*;
(
  input  logic [3:0]    i_v,
  input  logic [AW-1:0] i_ptr,
  output logic          o_found_c,
  output logic [AW-1:0] o_idx_c
);

  logic [7:0]    w_dbl;
  logic [3:0]    w_rot;
  logic [AW-1:0] w_off;

  // Rotate so bit 0 of w_rot is the port at i_ptr.
  assign w_dbl = {i_v, i_v};
  assign w_rot = 4'(w_dbl >> i_ptr);

  always_comb begin
    w_off = '0;
    casez (w_rot)
      4'b???1: w_off = AW'(0);
      4'b??10: w_off = AW'(1);
      4'b?100: w_off = AW'(2);
      4'b1000: w_off = AW'(3);
      default: w_off = '0;
    endcase
  end

  assign o_found_c = |i_v;
  assign o_idx_c   = i_ptr + w_off;

endmodule

// File: rtl/cory_arb4_pkt.sv
// Four-requester packet arbiter with registered output stage and source tag.
// Define CORY_ARB4_PKT_PKT_EN to hold grants for whole packets; otherwise every beat is a packet.
module cory_arb4_pkt
  import cory_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter bit          ROUND = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  cory_arb4_pkt_if.slave  bus
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_own;

  logic          r_z_v;
  logic [N-1:0]  r_z_d;
  logic          r_z_l;
  logic [AW-1:0] r_z_s;

  logic          w_ld;
  logic          w_found;
  logic [AW-1:0] w_cand;
  logic [AW-1:0] w_sel;
  logic [3:0]    w_rdy;
  logic          w_acc;
  logic          w_last;

  // Output register can take a beat when empty or draining this cycle.
  assign w_ld = ~r_z_v | bus.i_z_r;

  cory_rr_pick4 u_pick (
    .i_v       (bus.i_a_v),
    .i_ptr     (r_ptr),
    .o_found_c (w_found),
    .o_idx_c   (w_cand)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant selection, readies and next state.
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = '0;
    w_sel       = w_cand;
    w_acc       = 1'b0;
    w_last      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_sel        = w_cand;
        w_rdy[w_sel] = w_ld & w_found;
      end
      ST_LOCK: begin
        w_sel        = r_own;
        w_rdy[w_sel] = w_ld;
      end
      default: begin
        w_sel = w_cand;
      end
    endcase
    w_acc = |(w_rdy & bus.i_a_v);
`ifdef CORY_ARB4_PKT_PKT_EN
    w_last = bus.i_a_l[w_sel];
`else
    w_last = 1'b1;
`endif
    if (w_acc) w_state_nxt = w_last ? ST_IDLE : ST_LOCK;
  end

`ifndef CORY_ARB4_PKT_PKT_EN
  logic w_unused_l;
  assign w_unused_l = ^bus.i_a_l;
`endif

  // Output register, rotation pointer and packet owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_z_v <= 1'b0;
      r_z_d <= '0;
      r_z_l <= 1'b0;
      r_z_s <= '0;
      r_ptr <= '0;
      r_own <= '0;
    end else begin
      if (w_acc) begin
        r_z_v <= 1'b1;
        r_z_d <= bus.i_a_d[w_sel];
        r_z_l <= w_last;
        r_z_s <= w_sel;
        if (w_last) r_ptr <= ROUND ? inc_ptr(w_sel) : '0;
        else        r_own <= w_sel;
      end else if (bus.i_z_r) begin
        r_z_v <= 1'b0;
      end
    end
  end

`ifdef CORY_ARB4_PKT_PKT_EN
  logic r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= 1'b0;
    else          r_busy <= (w_state_nxt == ST_LOCK);
  end

  assign bus.o_busy = r_busy;
`else
  assign bus.o_busy = 1'b0;
`endif

  assign bus.o_a_r = w_rdy;
  assign bus.o_z_v = r_z_v;
  assign bus.o_z_d = r_z_d;
  assign bus.o_z_l = r_z_l;
  assign bus.o_z_s = r_z_s;

endmodule

// File: tb/tb_cory_arb4_pkt.sv
// Bench for cory_arb4_pkt: round-robin and fixed-priority instances share random
// stimulus and are each checked against a beat-level reference model.
module tb_cory_arb4_pkt;

  localparam int unsigned N = 8;
`ifdef CORY_ARB4_PKT_PKT_EN
  localparam bit PKT_EN = 1'b1;
`else
  localparam bit PKT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0]        s_v;
  logic [3:0]        s_l;
  logic [3:0][N-1:0] s_d;
  logic              s_zr;

  cory_arb4_pkt_if #(.N(N)) bus_rr ();
  cory_arb4_pkt_if #(.N(N)) bus_fx ();

  assign bus_rr.i_a_v = s_v;
  assign bus_rr.i_a_l = s_l;
  assign bus_rr.i_a_d = s_d;
  assign bus_rr.i_z_r = s_zr;
  assign bus_fx.i_a_v = s_v;
  assign bus_fx.i_a_l = s_l;
  assign bus_fx.i_a_d = s_d;
  assign bus_fx.i_z_r = s_zr;

  cory_arb4_pkt #(.N(N), .ROUND(1'b1)) u_dut_rr (.clk(clk), .reset_n(reset_n), .bus(bus_rr));
  cory_arb4_pkt #(.N(N), .ROUND(1'b0)) u_dut_fx (.clk(clk), .reset_n(reset_n), .bus(bus_fx));

  int n_chk = 0;
  int n_err = 0;

  // Reference model state per instance (0 = round-robin, 1 = fixed priority).
  int m_lock [2];
  int m_own  [2];
  int m_ptr  [2];
  int m_zv   [2];
  int m_zd   [2];
  int m_zl   [2];
  int m_zs   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = 0; m_own[k] = 0; m_ptr[k] = 0;
      m_zv[k] = 0; m_zd[k] = 0; m_zl[k] = 0; m_zs[k] = 0;
    end
  endtask

  function automatic logic [3:0] exp_rdy(input int k);
    logic [3:0] r;
    bit ld;
    bit done;
    int p;
    r = '0;
    done = 1'b0;
    ld = (m_zv[k] == 0) || s_zr;
    if (m_lock[k] != 0) begin
      r[m_own[k]] = ld;
    end else begin
      for (int j = 0; j < 4; j++) begin
        p = (m_ptr[k] + j) % 4;
        if (!done && s_v[p]) begin
          r[p] = ld;
          done = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_step(input int k);
    logic [3:0] r;
    int acc;
    bit last;
    r = exp_rdy(k);
    acc = -1;
    for (int p = 0; p < 4; p++) if (r[p] && s_v[p]) acc = p;
    if (acc >= 0) begin
      last = PKT_EN ? s_l[acc] : 1'b1;
      m_zv[k] = 1;
      m_zd[k] = int'(s_d[acc]);
      m_zl[k] = int'(last);
      m_zs[k] = acc;
      if (last) begin
        m_lock[k] = 0;
        m_ptr[k]  = (k == 0) ? (acc + 1) % 4 : 0;
      end else begin
        m_lock[k] = 1;
        m_own[k]  = acc;
      end
    end else if (s_zr) begin
      m_zv[k] = 0;
    end
  endtask

  task automatic check_outs();
    chk("rr_z_v",  32'(bus_rr.o_z_v),  32'(m_zv[0]));
    chk("rr_z_d",  32'(bus_rr.o_z_d),  32'(m_zd[0]));
    chk("rr_z_l",  32'(bus_rr.o_z_l),  32'(m_zl[0]));
    chk("rr_z_s",  32'(bus_rr.o_z_s),  32'(m_zs[0]));
    chk("rr_busy", 32'(bus_rr.o_busy), 32'(m_lock[0]));
    chk("fx_z_v",  32'(bus_fx.o_z_v),  32'(m_zv[1]));
    chk("fx_z_d",  32'(bus_fx.o_z_d),  32'(m_zd[1]));
    chk("fx_z_l",  32'(bus_fx.o_z_l),  32'(m_zl[1]));
    chk("fx_z_s",  32'(bus_fx.o_z_s),  32'(m_zs[1]));
    chk("fx_busy", 32'(bus_fx.o_busy), 32'(m_lock[1]));
  endtask

  // One cycle: readies checked mid-cycle, registers checked just after the edge.
  task automatic step();
    @(negedge clk);
    chk("rr_rdy", 32'(bus_rr.o_a_r), 32'(exp_rdy(0)));
    chk("fx_rdy", 32'(bus_fx.o_a_r), 32'(exp_rdy(1)));
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    check_outs();
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_rr_z_v",  32'(bus_rr.o_z_v),  32'd0);
    chk("rst_rr_busy", 32'(bus_rr.o_busy), 32'd0);
    chk("rst_rr_z_s",  32'(bus_rr.o_z_s),  32'd0);
    chk("rst_fx_z_v",  32'(bus_fx.o_z_v),  32'd0);
    chk("rst_fx_busy", 32'(bus_fx.o_busy), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  task automatic set_all_d(input logic [N-1:0] d);
    for (int p = 0; p < 4; p++) s_d[p] = d;
  endtask

  initial begin
    reset_n = 1'b0;
    s_v = '0; s_l = '1; s_zr = 1'b1;
    set_all_d('0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rr_z_v", 32'(bus_rr.o_z_v),  32'd0);
    chk("reset_rr_z_d", 32'(bus_rr.o_z_d),  32'd0);
    chk("reset_rr_z_l", 32'(bus_rr.o_z_l),  32'd0);
    chk("reset_rr_z_s", 32'(bus_rr.o_z_s),  32'd0);
    chk("reset_rr_busy", 32'(bus_rr.o_busy), 32'd0);
    #1 reset_n = 1'b1;

    // All ports valid, single beats: rotation 0,1,2,3,0 vs. fixed port 0.
    s_v = 4'hF; s_l = 4'hF;
    for (int i = 0; i < 5; i++) begin
      set_all_d(N'(8'h10 + i));
      step();
      chk("rot_seq_rr", 32'(bus_rr.o_z_s), 32'(i % 4));
      chk("rot_seq_fx", 32'(bus_fx.o_z_s), 32'd0);
      chk("rot_valid",  32'(bus_rr.o_z_v), 32'd1);
    end

    // Output stall holds data and drops every ready.
    set_all_d(N'(8'hA5));
    step();
    set_all_d(N'(8'h3C));
    s_zr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_data", 32'(bus_rr.o_z_d), 32'h0000_00A5);
      chk("stall_rdy",  32'(bus_rr.o_a_r), 32'd0);
    end
    s_zr = 1'b1;
    step();
    chk("stall_resume", 32'(bus_rr.o_z_d), 32'h0000_003C);

    // Fixed priority: port 0 starves port 3.
    s_v = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("starve_fx", 32'(bus_fx.o_z_s), 32'd0);
    end

`ifdef CORY_ARB4_PKT_PKT_EN
    // Port 2 three-beat packet while ports 0/1 stay valid, then port 3 is next.
    reset_pulse();
    s_v = 4'b0100; s_l = 4'b0000;
    step();
    chk("pkt_b1_s", 32'(bus_rr.o_z_s), 32'd2);
    chk("pkt_b1_busy", 32'(bus_rr.o_busy), 32'd1);
    s_v = 4'b0111;
    step();
    chk("pkt_b2_s", 32'(bus_rr.o_z_s), 32'd2);
    chk("pkt_b2_rdy", 32'(bus_rr.o_a_r), 32'b0100);
    s_l = 4'b0100;
    step();
    chk("pkt_b3_s", 32'(bus_rr.o_z_s), 32'd2);
    chk("pkt_b3_busy", 32'(bus_rr.o_busy), 32'd0);
    s_v = 4'b1011; s_l = 4'hF;
    step();
    chk("pkt_next", 32'(bus_rr.o_z_s), 32'd3);
`endif

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++) begin
        s_v[p] = ($urandom_range(0, 9) < 7);
        s_l[p] = ($urandom_range(0, 2) == 0);
        s_d[p] = N'($urandom);
      end
      s_zr = ($urandom_range(0, 3) != 0);
      step();
      if ($urandom_range(0, 299) == 0) reset_pulse();
    end

    // First grant after reset starts scanning from port 0.
    s_v = 4'hF; s_l = 4'h0; s_zr = 1'b1;
    step();
    reset_pulse();
    s_v = 4'b1100; s_l = 4'hF;
    step();
    chk("post_rst_rr", 32'(bus_rr.o_z_s), 32'd2);
    chk("post_rst_fx", 32'(bus_fx.o_z_s), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
